// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory.
//   - RV32I load/store funct3 codes
//   - controller state encoding
//   - response control record carried from accept to response cycle
//   - helpers: fault detection, store byte-enable mask, load extraction/extension
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int NUM_LANES = 4;  // byte lanes per 32-bit word

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    // What the response cycle needs to know about the accepted request.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] lane;
        logic       fault;
    } rsp_ctl_t;

    // Illegal funct3 or an address not aligned to the access size.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lane);
        logic flt;
        case (f3)
            F3_B, F3_BU: flt = 1'b0;
            F3_H, F3_HU: flt = lane[0];
            F3_W:        flt = (lane != 2'b00);
            default:     flt = 1'b1;
        endcase
        return flt;
    endfunction

    // Store byte-enable mask; size comes from funct3[1:0].
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated so the right-aligned byte/half lands on every lane.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            F3_W:    r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM, DEPTH_WORDS x 32, split into NUM_LANES byte lanes.
// Optional macro: DMEM_DBG_PORT_EN adds a combinational read-only debug port.
// Ports:
//   clk        clock
//   be         per-lane write strobes (write on rising edge)
//   addr       word index for write and read
//   wdata      write data (already lane-replicated)
//   rdata      registered read data of mem[addr]
//   word0      combinational view of word 0
//   dbg_addr   (DMEM_DBG_PORT_EN) debug word index
//   dbg_rdata  (DMEM_DBG_PORT_EN) combinational mem[dbg_addr]
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic [NUM_LANES-1:0] be,
    input  logic [IDX_W-1:0]     addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [31:0]          word0
`ifdef DMEM_DBG_PORT_EN
    ,
    input  logic [IDX_W-1:0]     dbg_addr,
    output logic [31:0]          dbg_rdata
`endif
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        // Read-before-write within a lane is irrelevant: the controller never
        // issues a load and a store on the same edge.
        always_ff @(posedge clk) begin
            if (be[l]) mem[addr] <= wdata[8*l +: 8];
            rd_q <= mem[addr];
        end

        assign rdata[8*l +: 8] = rd_q;
        assign word0[8*l +: 8] = mem[0];
`ifdef DMEM_DBG_PORT_EN
        assign dbg_rdata[8*l +: 8] = mem[dbg_addr];
`endif
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller for the RV32I pipeline.
// Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW with misalignment detection and a
// one-cycle registered response. After every reset a clear sequence writes one
// word per cycle (RESET_WORD0 into word 0, zero elsewhere); requests are
// refused until it completes.
// Optional macro: DMEM_DBG_PORT_EN adds dbg_addr / dbg_rdata.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       request strobe; accepted when req_ready
//   req_ready       high in IDLE
//   req_we          1 = store, 0 = load
//   req_addr        byte address (upper bits wrap)
//   req_funct3      RV32I funct3
//   req_wdata       right-aligned store data
//   rsp_valid       pulse one cycle after an accept
//   rsp_rdata       extended load data, 0 for stores/faults
//   rsp_fault       misaligned or illegal funct3
//   init_busy       clear sequence running
//   dm0             combinational word 0
//   dbg_addr/dbg_rdata  (DMEM_DBG_PORT_EN) combinational debug read
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter  int          DEPTH_WORDS = 256,
    parameter  logic [31:0] RESET_WORD0 = 32'd10,
    localparam int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_fault,
    output logic             init_busy,
    output logic [31:0]      dm0
`ifdef DMEM_DBG_PORT_EN
    ,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [31:0]      dbg_rdata
`endif
);

    localparam int STAGES = 1;

    state_t               state;
    logic [IDX_W-1:0]     clr_idx;
    logic [STAGES:0]      vld_pipe;   // [0] accept this edge, [1] response cycle
    rsp_ctl_t             ctl_q;

    logic [1:0]           lane;
    logic [IDX_W-1:0]     idx;
    logic                 fault;
    logic                 clearing;

    logic [NUM_LANES-1:0] arr_be;
    logic [IDX_W-1:0]     arr_addr;
    logic [31:0]          arr_wdata;
    logic [31:0]          arr_rdata;

    // Address bits above the array are ignored (wrap-around).
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign lane     = req_addr[1:0];
    assign idx      = req_addr[IDX_W+1:2];
    assign fault    = access_fault(req_funct3, lane);
    assign clearing = (state == ST_CLEAR);

    // rst gates accept so a request coinciding with reset neither writes nor responds.
    assign vld_pipe[0] = req_valid & req_ready & ~rst;

    always_comb begin
        arr_be    = '0;
        arr_addr  = idx;
        arr_wdata = store_data(req_funct3, req_wdata);
        if (clearing) begin
            arr_be    = '1;
            arr_addr  = clr_idx;
            arr_wdata = (clr_idx == '0) ? RESET_WORD0 : 32'd0;
        end else if (vld_pipe[0] && req_we && !fault) begin
            arr_be = store_be(req_funct3, lane);
        end
    end

    // Control FSM; req_ready and init_busy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            init_busy <= 1'b1;
            req_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                        state     <= ST_IDLE;
                        init_busy <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_CLEAR;
                    clr_idx   <= '0;
                    init_busy <= 1'b1;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            ctl_q              <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            ctl_q              <= '{we: req_we, funct3: req_funct3, lane: lane, fault: fault};
        end
    end

    assign rsp_valid = vld_pipe[STAGES];
    assign rsp_fault = vld_pipe[STAGES] & ctl_q.fault;
    assign rsp_rdata = (vld_pipe[STAGES] && !ctl_q.we && !ctl_q.fault)
                     ? load_ext(ctl_q.funct3, ctl_q.lane, arr_rdata) : 32'd0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .be        (arr_be),
        .addr      (arr_addr),
        .wdata     (arr_wdata),
        .rdata     (arr_rdata),
        .word0     (dm0)
`ifdef DMEM_DBG_PORT_EN
        ,
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
`endif
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed test-plan cases plus randomized
// traffic against a word-array reference model.
module tb_dmem_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        init_busy;
    logic [31:0] dm0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .RESET_WORD0(32'd10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .init_busy  (init_busy),
        .dm0        (dm0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain word array plus the expected next response.
    int unsigned mdl [DEPTH];
    bit          exp_v;
    int unsigned exp_rd;
    bit          exp_f;

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
        mdl[0] = 10;
        exp_v = 0; exp_rd = 0; exp_f = 0;
    endtask

    // Called at a negedge while IDLE: check the response to the previous
    // cycle's request, then present the next one. Returns at the next negedge.
    task automatic step(input bit v, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        int          sz, idx, ln, pos;
        int unsigned val;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_f});
        chk("dm0", dm0, mdl[0]);
        chk("req_ready", {31'd0, req_ready}, 32'd1);

        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;

        exp_v = v; exp_rd = 0; exp_f = 0;
        if (v) begin
            sz  = acc_size(f3);
            idx = int'((addr >> 2) % DEPTH);
            ln  = int'(addr % 4);
            if (sz == 0 || (ln % sz) != 0) begin
                exp_f = 1;
            end else if (we) begin
                for (int k = 0; k < sz; k++) begin
                    pos = ln + k;
                    mdl[idx] = (mdl[idx] & ~(32'hFF << (8 * pos)))
                             | (((wd >> (8 * k)) & 32'hFF) << (8 * pos));
                end
            end else begin
                val = mdl[idx] >> (8 * ln);
                if (sz == 1) begin
                    val = val & 32'hFF;
                    if (f3 == 3'd0 && val >= 128) val = val | 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    val = val & 32'hFFFF;
                    if (f3 == 3'd1 && val >= 32768) val = val | 32'hFFFF_0000;
                end
                exp_rd = val;
            end
        end
        @(negedge clk);
    endtask

    // Sample init_busy each negedge; also flags ready/valid activity during clear.
    int ready_bad, vld_bad;
    task automatic count_busy(input int stop_at, output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 1000 && n != stop_at) begin
            if (req_ready !== 1'b0) ready_bad++;
            if (rsp_valid !== 1'b0) vld_bad++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [2:0]  f3;
        bit          we;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_funct3 = '0; req_wdata = '0;
        ready_bad = 0; vld_bad = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);

        // Hold a store to word 0 during the clear: it must be refused.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;

        // Interrupted clear, then a full one
        rst = 1'b0;
        count_busy(100, n);
        chk("clear_partial", n, 32'd100);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, init_busy}, 32'd1);
        rst = 1'b0;
        count_busy(-1, n);
        chk("clear_len", n, 32'd256);
        chk("ready_in_clear", ready_bad, 32'd0);
        chk("valid_in_clear", vld_bad, 32'd0);
        model_clear();
        chk("dm0_after_clear", dm0, 32'd10);

        // Directed cases
        step(1, 0, 3'd2, 32'h40,  32'h0);          // LW 0x40
        step(1, 1, 3'd2, 32'h80,  32'h1122_3344);  // SW
        step(1, 1, 3'd0, 32'h81,  32'h0000_00F0);  // SB
        step(1, 0, 3'd2, 32'h80,  32'h0);          // LW -> 1122F044
        step(1, 0, 3'd0, 32'h81,  32'h0);          // LB -> FFFFFFF0
        step(1, 0, 3'd4, 32'h81,  32'h0);          // LBU -> F0
        step(1, 1, 3'd1, 32'h102, 32'h0000_BEEF);  // SH
        step(1, 0, 3'd1, 32'h102, 32'h0);          // LH -> FFFFBEEF
        step(1, 0, 3'd5, 32'h102, 32'h0);          // LHU -> BEEF
        step(1, 0, 3'd2, 32'h100, 32'h0);          // LW -> BEEF0000
        step(1, 1, 3'd2, 32'h21,  32'hDEAD_BEEF);  // misaligned SW
        step(1, 0, 3'd2, 32'h20,  32'h0);          // unchanged
        step(1, 0, 3'd1, 32'h23,  32'h0);          // misaligned LH
        step(1, 0, 3'd3, 32'h24,  32'h0);          // illegal funct3
        step(1, 1, 3'd2, 32'h0,   32'd5);          // SW 0x0 <- 5
        step(1, 0, 3'd2, 32'h400, 32'h0);          // LW 0x400 wraps to word 0
        step(0, 0, 3'd0, 32'h0,   32'h0);          // checks LW result
        step(0, 0, 3'd0, 32'h0,   32'h0);
        chk("dm0_wrap", dm0, 32'd5);

        // Randomized traffic over a small window of words, random upper bits
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 1) == 1);
            if (we) begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
                    3: f3 = 3'd3; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                if ($urandom_range(0, 7) != 0 && f3 >= 3'd3) f3 = 3'(f3 % 3);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 31)) << 2)
              | 32'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, we, f3, a, $urandom);
        end
        step(0, 0, 3'd0, 32'h0, 32'h0);

        // Reset coinciding with a request: no response, full clear again
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_busy", {31'd0, init_busy}, 32'd1);
        rst = 1'b0;
        ready_bad = 0; vld_bad = 0;
        count_busy(-1, n);
        chk("clear_len2", n, 32'd256);
        chk("valid_in_clear2", vld_bad, 32'd0);
        model_clear();
        step(1, 0, 3'd2, 32'h80, 32'h0);           // cleared word reads 0
        step(1, 0, 3'd2, 32'h0,  32'h0);           // word 0 reads 10
        step(0, 0, 3'd0, 32'h0,  32'h0);
        step(0, 0, 3'd0, 32'h0,  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
